rs485_tx: RTL and testbench

RS485_TX -- requirements
Module: rs485_tx

---
 rtl/rs485_pkg.sv | 20 ++
 rtl/rs485_baud_cnt.sv | 32 +++
 rtl/rs485_tx.sv | 145 ++++++++++++++
 tb/tb_rs485_tx.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs485_pkg.sv
// Shared definitions for the RS-485 transmitter.
//   state_e  : frame sequencer states
//   PAR_*    : parity-mode encodings for the PARITY parameter
package rs485_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLead,
    StStart,
    StData,
    StPar,
    StStop,
    StTail
  } state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

endpackage

// File: rtl/rs485_baud_cnt.sv
// Per-bit cycle counter for the RS-485 transmitter.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   clear   : hold the count at zero (asserted outside bit states)
//   bit_end : high on the last cycle of each CLK_DIV-cycle bit period
module rs485_baud_cnt #(
  parameter int unsigned CLK_DIV = 2604
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (cnt_q == CntLast) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bit_end = !clear && (cnt_q == CntLast);

endmodule

// File: rtl/rs485_tx.sv
// RS-485 frame transmitter with driver-enable lead/tail timing.
//   clk, rst : clock and synchronous active-high reset
//   tx_valid : frame request; accepted when tx_ready is also high
//   tx_data  : payload, sent LSB first
//   tx_ready : can accept a frame this cycle (IDLE or TAIL)
//   tx       : registered serial line, idle high
//   de       : registered driver enable
//   busy     : sequencer not in IDLE
//   done     : pulse on the last cycle of the final stop bit
module rs485_tx
  import rs485_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2604,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 1,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned DE_LEAD   = 16,
  parameter int unsigned DE_TAIL   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 de,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned LeadLast = (DE_LEAD > 0) ? DE_LEAD - 1 : 0;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] data_q;
  logic [2:0]           idx_q, idx_d;
  logic [15:0]          cyc_q, cyc_d;
  logic                 rst_q;
  logic                 tx_q, tx_d, de_q, de_d;
  logic                 in_bit, bit_end, accept;
  logic                 last_data, last_stop, lead_end, tail_end, par_bit;

  assign in_bit = state_q inside {StStart, StData, StPar, StStop};

  rs485_baud_cnt #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_bit),
    .bit_end(bit_end)
  );

  // rst_q keeps tx_ready low for the cycle right after a sampled reset.
  assign tx_ready  = (state_q == StIdle || state_q == StTail) && !rst && !rst_q;
  assign accept    = tx_valid && tx_ready;
  assign last_data = (idx_q == 3'(DATA_BITS - 1));
  assign last_stop = (idx_q == 3'(STOP_BITS - 1));
  assign lead_end  = (cyc_q == 16'(LeadLast));
  assign tail_end  = (cyc_q == 16'(DE_TAIL - 1));
  assign par_bit   = (^data_q) ^ (PARITY == PAR_ODD);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = (DE_LEAD == 0) ? StStart : StLead;
      StLead:  if (lead_end) state_d = StStart;
      StStart: if (bit_end) state_d = StData;
      StData:  if (bit_end && last_data) state_d = (PARITY != PAR_NONE) ? StPar : StStop;
      StPar:   if (bit_end) state_d = StStop;
      StStop:  if (bit_end && last_stop) state_d = StTail;
      StTail: begin
        if (accept) begin
          state_d = StStart;
        end else if (tail_end) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bit index and lead/tail cycle counters restart on every state change.
  always_comb begin
    idx_d = idx_q;
    cyc_d = '0;
    if (state_d != state_q) begin
      idx_d = '0;
    end else begin
      if (bit_end && (state_q == StData || state_q == StStop)) begin
        idx_d = idx_q + 3'd1;
      end
      if (state_q == StLead || state_q == StTail) begin
        cyc_d = cyc_q + 16'd1;
      end
    end
  end

  // Output logic; tx/de are computed from the next state so the registered
  // line lines up with the state register.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = data_q[idx_d];
      StPar:   tx_d = par_bit;
      default: tx_d = 1'b1;
    endcase
    de_d = (state_d != StIdle);
    busy = (state_q != StIdle);
    done = (state_q == StStop) && bit_end && last_stop;
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      idx_q  <= '0;
      cyc_q  <= '0;
      tx_q   <= 1'b1;
      de_q   <= 1'b0;
      data_q <= '0;
    end else begin
      idx_q <= idx_d;
      cyc_q <= cyc_d;
      tx_q  <= tx_d;
      de_q  <= de_d;
      if (accept) begin
        data_q <= tx_data;
      end
    end
  end

  assign tx = tx_q;
  assign de = de_q;

endmodule

// File: tb/tb_rs485_tx.sv
module tb_rs485_tx;

  localparam int unsigned Div  = 4;
  localparam int unsigned Lead = 2;
  localparam int unsigned Tail = 3;

  logic       clk;
  logic [2:0] rst_v, valid_v;
  logic [7:0] data_v [3];
  logic [2:0] ready_v, tx_v, de_v, busy_v, done_v;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rs485_tx #(.CLK_DIV(Div), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
             .DE_LEAD(Lead), .DE_TAIL(Tail)) u_even (
    .clk(clk), .rst(rst_v[0]), .tx_valid(valid_v[0]), .tx_data(data_v[0]),
    .tx_ready(ready_v[0]), .tx(tx_v[0]), .de(de_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  rs485_tx #(.CLK_DIV(Div), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
             .DE_LEAD(Lead), .DE_TAIL(Tail)) u_odd (
    .clk(clk), .rst(rst_v[1]), .tx_valid(valid_v[1]), .tx_data(data_v[1]),
    .tx_ready(ready_v[1]), .tx(tx_v[1]), .de(de_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  rs485_tx #(.CLK_DIV(Div), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2),
             .DE_LEAD(Lead), .DE_TAIL(Tail)) u_7n2 (
    .clk(clk), .rst(rst_v[2]), .tx_valid(valid_v[2]), .tx_data(data_v[2][6:0]),
    .tx_ready(ready_v[2]), .tx(tx_v[2]), .de(de_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: a frame is a timeline of Lead cycles, then nbits bit
  // periods of Div cycles each, then Tail cycles; k counts cycles since accept.
  int nb_c  [3] = '{8, 8, 7};
  int par_c [3] = '{1, 2, 0};
  int stp_c [3] = '{1, 1, 2};
  bit         act_m [3];
  int         k_m   [3];
  int         lead_m[3];
  logic [7:0] dat_m [3];
  bit         rflag [3];
  bit         cmp_en = 1'b0;

  function automatic int nbits(input int d);
    return 1 + nb_c[d] + ((par_c[d] != 0) ? 1 : 0) + stp_c[d];
  endfunction

  function automatic int flen(input int d);
    return lead_m[d] + nbits(d) * Div + Tail;
  endfunction

  function automatic logic bit_val(input int d, input int b);
    logic [7:0] v;
    v = dat_m[d];
    if (b == 0) return 1'b0;
    if (b <= nb_c[d]) return v[b-1];
    if (par_c[d] != 0 && b == nb_c[d] + 1) return (^v) ^ (par_c[d] == 2);
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      bit rdy, was;
      rdy = !rst_v[d] && !rflag[d] && (!act_m[d] || k_m[d] >= flen(d) - Tail);
      if (rst_v[d]) begin
        act_m[d] = 1'b0;
        rflag[d] = 1'b1;
        cmp_en   = 1'b1;
      end else begin
        was      = act_m[d];
        rflag[d] = 1'b0;
        if (act_m[d]) begin
          k_m[d]++;
          if (k_m[d] >= flen(d)) act_m[d] = 1'b0;
        end
        if (valid_v[d] && rdy) begin
          lead_m[d] = was ? 0 : Lead;
          dat_m[d]  = data_v[d] & 8'((1 << nb_c[d]) - 1);
          k_m[d]    = 0;
          act_m[d]  = 1'b1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      for (int d = 0; d < 3; d++) begin
        logic e_tx, e_de, e_busy, e_done, e_rdy;
        int b, r;
        e_tx = 1'b1; e_de = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        e_rdy = !rst_v[d] && !rflag[d];
        if (act_m[d]) begin
          e_de = 1'b1; e_busy = 1'b1; e_rdy = 1'b0;
          if (k_m[d] >= lead_m[d]) begin
            b = (k_m[d] - lead_m[d]) / Div;
            r = (k_m[d] - lead_m[d]) % Div;
            if (b < nbits(d)) begin
              e_tx   = bit_val(d, b);
              e_done = (b == nbits(d) - 1) && (r == Div - 1);
            end else begin
              e_rdy = !rst_v[d];
            end
          end
        end
        check($sformatf("dut%0d tx", d), tx_v[d], e_tx);
        check($sformatf("dut%0d de", d), de_v[d], e_de);
        check($sformatf("dut%0d busy", d), busy_v[d], e_busy);
        check($sformatf("dut%0d done", d), done_v[d], e_done);
        check($sformatf("dut%0d tx_ready", d), ready_v[d], e_rdy);
      end
    end
  end

  // Raise tx_valid and return just after the accepting edge.
  task automatic send(input int d, input logic [7:0] v, input bit hold);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    @(posedge clk); #2;
    valid_v[d] = 1'b1;
    data_v[d]  = v;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (ready_v[d]) ok = 1'b1;
      n++;
      @(posedge clk); #2;
    end
    if (!hold) valid_v[d] = 1'b0;
    check($sformatf("dut%0d accept", d), ok, 1'b1);
  endtask

  // Sample a frame starting at the first cycle after acceptance.
  task automatic trace(input int d, input int nb, output logic [15:0] bits,
                       output int start_k, output int done_k, output int ndone,
                       output int de_low_k, output int de_rise);
    bits = '0; start_k = -1; done_k = -1; ndone = 0; de_low_k = -1; de_rise = -1;
    for (int k = 0; k < Lead + nb * Div + Tail + 3; k++) begin
      @(negedge clk);
      if (de_v[d] && de_rise < 0) de_rise = k;
      if (!tx_v[d] && start_k < 0) start_k = k;
      if (k >= Lead && (k - Lead) % Div == 1 && (k - Lead) / Div < nb)
        bits[(k - Lead) / Div] = tx_v[d];
      if (done_v[d]) begin
        ndone++;
        done_k = k;
      end
      if (!de_v[d] && de_rise >= 0 && de_low_k < 0) de_low_k = k;
    end
  endtask

  task automatic wait_done(input int d, output int n_low);
    bit seen;
    seen  = 1'b0;
    n_low = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (!de_v[d]) n_low++;
      if (done_v[d]) seen = 1'b1;
    end
    check($sformatf("dut%0d done seen", d), seen, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bits;
    int start_k, done_k, ndone, de_low_k, de_rise, n_low;

    rst_v   = 3'b111;
    valid_v = 3'b000;
    for (int d = 0; d < 3; d++) data_v[d] = 8'h00;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset tx", tx_v, 3'b111);
    check("reset de", de_v, 3'b000);
    check("reset busy", busy_v, 3'b000);
    check("reset tx_ready", ready_v, 3'b000);
    @(posedge clk); #2;
    rst_v = 3'b000;
    @(negedge clk);
    check("reset ready low", ready_v, 3'b000);
    @(negedge clk);
    check("ready after reset", ready_v, 3'b111);

    // Even parity, 0xA5
    send(0, 8'hA5, 1'b0);
    trace(0, 11, bits, start_k, done_k, ndone, de_low_k, de_rise);
    check("A5 bits", bits, 16'h054A);
    check("A5 de rise", de_rise, 0);
    check("A5 start", start_k, 2);
    check("A5 done count", ndone, 1);
    check("A5 done cycle", done_k, 45);
    check("A5 de low", de_low_k, 49);

    // Odd parity
    send(1, 8'h00, 1'b0);
    trace(1, 11, bits, start_k, done_k, ndone, de_low_k, de_rise);
    check("odd 00 bits", bits, 16'h0600);
    check("odd 00 parity", bits[9], 1'b1);
    send(1, 8'h01, 1'b0);
    trace(1, 11, bits, start_k, done_k, ndone, de_low_k, de_rise);
    check("odd 01 bits", bits, 16'h0402);
    check("odd 01 parity", bits[9], 1'b0);

    // Back-to-back: second frame accepted during TAIL
    send(0, 8'hA5, 1'b0);
    wait_done(0, n_low);
    send(0, 8'h3C, 1'b0);
    @(negedge clk);
    check("b2b start", tx_v[0], 1'b0);
    check("b2b de", de_v[0], 1'b1);
    wait_done(0, n_low);
    check("b2b de drops", n_low, 0);
    repeat (8) @(posedge clk);

    // Reset during DATA bit 3
    send(0, 8'h5A, 1'b0);
    for (int k = 0; k < 20; k++) @(negedge clk);
    @(posedge clk); #2;
    rst_v[0] = 1'b1;
    @(posedge clk); #2;
    rst_v[0] = 1'b0;
    @(negedge clk);
    check("mid rst tx", tx_v[0], 1'b1);
    check("mid rst de", de_v[0], 1'b0);
    check("mid rst busy", busy_v[0], 1'b0);
    check("mid rst done", done_v[0], 1'b0);
    check("mid rst ready", ready_v[0], 1'b0);
    @(negedge clk);
    check("post rst ready", ready_v[0], 1'b1);
    ndone = 0;
    repeat (50) begin
      @(negedge clk);
      if (done_v[0]) ndone++;
    end
    check("mid rst no done", ndone, 0);

    // tx_valid held with changing tx_data mid-frame
    send(1, 8'h96, 1'b1);
    fork
      trace(1, 11, bits, start_k, done_k, ndone, de_low_k, de_rise);
      begin
        repeat (38) begin
          @(posedge clk); #2;
          data_v[1] = 8'($urandom);
        end
        valid_v[1] = 1'b0;
      end
    join
    check("hold bits", bits, 16'h072C);
    check("hold done count", ndone, 1);
    check("hold de low", de_low_k, 49);

    // 7 data bits, no parity, 2 stop bits
    send(2, 8'h41, 1'b0);
    trace(2, 10, bits, start_k, done_k, ndone, de_low_k, de_rise);
    check("7n2 bits", bits, 16'h0382);
    check("7n2 frame length", done_k - start_k + 1, 40);
    check("7n2 done cycle", done_k, 41);
    check("7n2 de low", de_low_k, 45);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
